// File: rtl/dpram_pkg.sv
// Shared definitions for dual-port RAM users: default geometry and the
// readout controller state encoding.
package dpram_pkg;

  localparam int unsigned DPRAM_ADDR_WIDTH = 11;
  localparam int unsigned DPRAM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs RAM read data while the stream is stalled.
// Push is ignored when full and pop is ignored when empty.
module skid_fifo2
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DPRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  // Status flags, qualified handshakes and head-of-queue data.
  always_comb begin
    full    = (count == 2'd2);
    empty   = (count == 2'd0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dpram_reader.sv
// Reads a block of consecutive words from a synchronous RAM port and
// presents them as a ready/valid stream with a last-beat marker.
module dpram_reader
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DPRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DPRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  en_b,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  reader_state_t       state;
  reader_state_t       state_next;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] rd_left;
  logic [ADDR_WIDTH:0] beat_cnt;
  logic                rd_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                issue;
  logic [2:0]          occupancy;

  assign we_b = 1'b0;

  skid_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_valid),
    .pop   (pop),
    .din   (out_b),
    .dout  (m_tdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stream handshake and read-credit check. A word popped this cycle frees
  // its slot in time for a read issued now, which sustains one beat per cycle
  // across the two-cycle RAM-to-buffer latency.
  always_comb begin
    m_tvalid  = !fifo_empty;
    pop       = m_tvalid && m_tready;
    m_tlast   = m_tvalid && (beat_cnt == (len_q - LEN_ONE));
    occupancy = {1'b0, fifo_full, !fifo_empty && !fifo_full} + {2'b00, rd_valid};
    issue     = (state == READ) && (rd_left != '0)
                && (occupancy < (3'd2 + {2'b00, pop}));
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_next = state;
    en_b       = issue;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start && (length != '0)) state_next = READ;
      READ:    if (issue && (rd_left == LEN_ONE)) state_next = DRAIN;
      DRAIN:   if (pop && m_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address, read/beat counters, in-flight flag and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_b   <= '0;
      len_q    <= '0;
      rd_left  <= '0;
      beat_cnt <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= issue;
      if (state == IDLE) begin
        if (start) begin
          addr_b   <= start_addr;
          len_q    <= length;
          rd_left  <= length;
          beat_cnt <= '0;
          done     <= (length == '0);
        end
      end else begin
        if (issue) begin
          addr_b  <= addr_b + ADDR_ONE;
          rd_left <= rd_left - LEN_ONE;
        end
        if (pop) begin
          beat_cnt <= beat_cnt + LEN_ONE;
          if (m_tlast) begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
